// File: rtl/systolic_seq_ctrl_if.sv
// rtl/systolic_seq_ctrl_if.sv - job, operand and result handshake bundle for the systolic sequencer
interface systolic_seq_ctrl_if #(
   parameter int LEN_W     = 8,
   parameter int acc_width = 24
);
   logic                 start;
   logic [LEN_W-1:0]     len;
   logic                 op_valid;
   logic                 op_ready;
   logic                 mac_reset;
   logic                 mac_control;
   logic [acc_width-1:0] chain_acc;
   logic [acc_width-1:0] result;
   logic                 result_valid;
   logic                 result_ready;
   logic                 busy;

   // requester / MAC chain side
   modport master (
      output start, len, op_valid, chain_acc, result_ready,
      input  op_ready, mac_reset, mac_control, result, result_valid, busy
   );

   // sequencer side
   modport slave (
      input  start, len, op_valid, chain_acc, result_ready,
      output op_ready, mac_reset, mac_control, result, result_valid, busy
   );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - job sequencer feeding a MAC chain and summing its tapped outputs
module systolic_seq_ctrl #(
   parameter int bit_width = 8,
   parameter int acc_width = 24,
   parameter int NUM_PE    = 4,
   parameter int LEN_W     = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   systolic_seq_ctrl_if.slave bus
);

   // Valid-pipe depth; a degenerate configuration falls back to the minimum legal chain.
   localparam int P = (NUM_PE >= 2 && bit_width > 0) ? NUM_PE : 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [LEN_W-1:0]     r_cnt;
   logic [P-1:0]         r_vld;
   logic [acc_width-1:0] r_result;

   logic w_op_ready;
   logic w_beat;
   logic w_load;
   logic w_mac_reset;
   logic w_busy;
   logic w_result_valid;

   // state register; reset wins over every transition
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state and handshake outputs; reset masks everything except mac_reset
   always_comb begin
      w_state_nxt    = r_state;
      w_op_ready     = 1'b0;
      w_busy         = 1'b0;
      w_result_valid = 1'b0;
      w_mac_reset    = i_reset;
      w_load         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_busy      = 1'b1;
            w_mac_reset = 1'b1;
            w_state_nxt = (r_cnt != '0) ? S_FEED : S_DRAIN;
         end
         S_FEED: begin
            w_busy     = 1'b1;
            w_op_ready = 1'b1;
            if (bus.op_valid && r_cnt == LEN_W'(1)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            // only the last tap may still be in flight when we leave
            if (r_vld[P-2:0] == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_busy         = 1'b1;
            w_result_valid = 1'b1;
            if (bus.result_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (i_reset) begin
         w_op_ready     = 1'b0;
         w_busy         = 1'b0;
         w_result_valid = 1'b0;
         w_load         = 1'b0;
      end
      w_beat = w_op_ready & bus.op_valid;
   end

   // beat counter, valid pipe tracking beats through the chain, and the job sum
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt    <= '0;
         r_vld    <= '0;
         r_result <= '0;
      end else begin
         if (w_load) begin
            r_cnt <= bus.len;
         end else if (w_beat) begin
            r_cnt <= r_cnt - LEN_W'(1);
         end
         if (r_state == S_CLEAR) begin
            r_vld    <= '0;
            r_result <= '0;
         end else begin
            r_vld <= {r_vld[P-2:0], w_beat};
            if (r_vld[P-1]) begin
               r_result <= r_result + bus.chain_acc;
            end
         end
      end
   end

   assign bus.op_ready     = w_op_ready;
   assign bus.mac_control  = w_beat;
   assign bus.mac_reset    = w_mac_reset;
   assign bus.busy         = w_busy;
   assign bus.result_valid = w_result_valid;
   assign bus.result       = r_result;

endmodule
